// File: rtl/stack_alu_ctrl_pkg.sv
// Shared definitions for the stack-machine ALU sequencer: instruction kinds,
// FSM states, error codes, ALU select codes and select-legality helpers.
package stack_alu_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        KIND_PUSH = 2'b00,
        KIND_DROP = 2'b01,
        KIND_BIN  = 2'b10,
        KIND_UN   = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ERR  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_ILLEGAL   = 2'b11
    } err_e;

    localparam logic [SEL_W-1:0] SEL_NOP  = 4'h0;
    localparam logic [SEL_W-1:0] SEL_INV  = 4'hC;
    localparam logic [SEL_W-1:0] SEL_SWAP = 4'hD;

    function automatic logic sel_legal(input kind_e kind, input logic [SEL_W-1:0] sel);
        case (kind)
            KIND_BIN: sel_legal = sel inside {4'h1, 4'h2, 4'h3, 4'h6, 4'h7,
                                              4'h8, 4'h9, 4'hA, 4'hB};
            KIND_UN:  sel_legal = sel inside {SEL_NOP, SEL_INV, SEL_SWAP};
            default:  sel_legal = 1'b1;
        endcase
    endfunction

    // Minimum live entries an instruction needs before it may execute.
    function automatic logic [1:0] min_depth(input kind_e kind, input logic [SEL_W-1:0] sel);
        case (kind)
            KIND_PUSH: min_depth = 2'd0;
            KIND_DROP: min_depth = 2'd1;
            KIND_BIN:  min_depth = 2'd2;
            default:   min_depth = (sel == SEL_SWAP) ? 2'd2 :
                                   (sel == SEL_INV)  ? 2'd1 : 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_alu_ctrl_spill_ram.sv
// Spill RAM for stack entries below tos/next: synchronous write, asynchronous read.
module stack_alu_ctrl_spill_ram
    import stack_alu_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; depth tracking guarantees an entry is
    // written before it is ever read, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_alu_ctrl.sv
// Stack-machine ALU sequencer: holds tos/next, spills deeper entries to RAM,
// drives the external ALU and retires one instruction per two cycles.
module stack_alu_ctrl
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_kind,
    input  logic [3:0]    in_sel,
    input  logic [15:0]   in_lit,
    output logic [15:0]   alu_tos,
    output logic [15:0]   alu_next,
    output logic [3:0]    alu_select,
    input  logic [15:0]   alu_o_tos,
    input  logic [15:0]   alu_o_next,
    output logic [15:0]   tos,
    output logic [15:0]   next,
    output logic [AW+1:0] depth,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    input  logic          err_clr
);
    import stack_alu_ctrl_pkg::*;

    localparam int             DW        = AW + 2;
    localparam logic [DW-1:0]  MAX_DEPTH = DW'(DEPTH + 2);

    state_e            state_q, state_d;
    kind_e             kind_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] lit_q;
    logic [DATA_W-1:0] tos_q, tos_d, next_q, next_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              done_q, done_d, err_q, err_d;
    err_e              err_code_q, err_code_d;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_rdata, fill;

    // Entry below next lives at ram[depth-3]; a spilled next goes to ram[depth-2].
    assign ram_waddr = AW'(depth_q - DW'(2));
    assign ram_raddr = AW'(depth_q - DW'(3));
    assign fill      = (depth_q >= DW'(3)) ? ram_rdata : '0;

    stack_alu_ctrl_spill_ram #(.DEPTH(DEPTH), .AW(AW)) u_spill_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (next_q),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        tos_d      = tos_q;
        next_d     = next_q;
        depth_d    = depth_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        ram_we     = 1'b0;
        in_ready   = (state_q == ST_IDLE);
        alu_select = '0;

        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_EXEC;

            ST_EXEC: begin
                if (kind_q == KIND_BIN || kind_q == KIND_UN) alu_select = sel_q;
                state_d = ST_IDLE;
                if (!sel_legal(kind_q, sel_q)) begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_ILLEGAL;
                end else if (kind_q == KIND_PUSH && depth_q == MAX_DEPTH) begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERFLOW;
                end else if (depth_q < DW'(min_depth(kind_q, sel_q))) begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_UNDERFLOW;
                end else begin
                    done_d = 1'b1;
                    case (kind_q)
                        KIND_PUSH: begin
                            ram_we  = (depth_q >= DW'(2));
                            next_d  = tos_q;
                            tos_d   = lit_q;
                            depth_d = depth_q + DW'(1);
                        end
                        KIND_DROP: begin
                            tos_d   = (depth_q == DW'(1)) ? '0 : next_q;
                            next_d  = fill;
                            depth_d = depth_q - DW'(1);
                        end
                        KIND_BIN: begin
                            tos_d   = alu_o_tos;
                            next_d  = fill;
                            depth_d = depth_q - DW'(1);
                        end
                        default: begin
                            if (sel_q == SEL_INV || sel_q == SEL_SWAP) tos_d = alu_o_tos;
                            if (sel_q == SEL_SWAP) next_d = alu_o_next;
                        end
                    endcase
                end
            end

            ST_ERR: begin
                if (err_clr) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            kind_q     <= KIND_PUSH;
            sel_q      <= '0;
            lit_q      <= '0;
            tos_q      <= '0;
            next_q     <= '0;
            depth_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            tos_q      <= tos_d;
            next_q     <= next_d;
            depth_q    <= depth_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            if (state_q == ST_IDLE && in_valid) begin
                kind_q <= kind_e'(in_kind);
                sel_q  <= in_sel;
                lit_q  <= in_lit;
            end
        end
    end

    assign alu_tos  = tos_q;
    assign alu_next = next_q;
    assign tos      = tos_q;
    assign next     = next_q;
    assign depth    = depth_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_stack_alu_ctrl.sv
// Scoreboard bench for stack_alu_ctrl: a queue-based stack model predicts each
// retirement; a monitor compares whenever done pulses or err rises.
module tb_stack_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'b00;
    logic [3:0]  in_sel = 4'h0;
    logic [15:0] in_lit = 16'h0;
    logic [15:0] alu_tos, alu_next, alu_o_tos, alu_o_next;
    logic [3:0]  alu_select;
    logic [15:0] tos, next;
    logic [5:0]  depth;
    logic        done, err, err_clr = 1'b0;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [15:0] tos;
        logic [15:0] next;
        int          depth;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mstk[$];
    logic        err_prev = 1'b0;

    stack_alu_ctrl #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_sel(in_sel), .in_lit(in_lit),
        .alu_tos(alu_tos), .alu_next(alu_next), .alu_select(alu_select),
        .alu_o_tos(alu_o_tos), .alu_o_next(alu_o_next),
        .tos(tos), .next(next), .depth(depth), .done(done),
        .err(err), .err_code(err_code), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Reference ALU; next result is poisoned except for swap.
    function automatic logic [15:0] alu_fn(input logic [3:0] s, input logic [15:0] t,
                                           input logic [15:0] n);
        case (s)
            4'h1:    alu_fn = n + t;
            4'h2:    alu_fn = n - t;
            4'h3:    alu_fn = n & t;
            4'h6:    alu_fn = n | t;
            4'h7:    alu_fn = n ^ t;
            4'h8:    alu_fn = n << t[3:0];
            4'h9:    alu_fn = n >> t[3:0];
            4'hA:    alu_fn = 16'(n * t);
            4'hB:    alu_fn = {15'b0, n < t};
            4'hC:    alu_fn = ~t;
            4'hD:    alu_fn = n;
            default: alu_fn = 16'hBAD0;
        endcase
    endfunction

    assign alu_o_tos  = alu_fn(alu_select, alu_tos, alu_next);
    assign alu_o_next = (alu_select == 4'hD) ? alu_tos : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_op(input logic [1:0] k, input logic [3:0] s, input logic [15:0] l);
        exp_t        e;
        logic [15:0] t, n;
        logic        legal;
        int          need, sz;
        sz    = mstk.size();
        legal = (k <= 2'd1) ||
                (k == 2'd2 && s inside {4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB}) ||
                (k == 2'd3 && s inside {4'h0, 4'hC, 4'hD});
        need  = (k == 2'd0) ? 0 : (k == 2'd1) ? 1 : (k == 2'd2) ? 2 :
                (s == 4'hC) ? 1 : (s == 4'hD) ? 2 : 0;
        if (!legal)                  e.code = 2'b11;
        else if (k == 2'd0 && sz == 18) e.code = 2'b01;
        else if (sz < need)          e.code = 2'b10;
        else                         e.code = 2'b00;
        if (e.code == 2'b00) begin
            case (k)
                2'd0: mstk.push_back(l);
                2'd1: void'(mstk.pop_back());
                2'd2: begin
                    t = mstk.pop_back();
                    n = mstk.pop_back();
                    mstk.push_back(alu_fn(s, t, n));
                end
                default: begin
                    if (s == 4'hC) mstk[sz-1] = ~mstk[sz-1];
                    else if (s == 4'hD) begin
                        t = mstk[sz-1];
                        mstk[sz-1] = mstk[sz-2];
                        mstk[sz-2] = t;
                    end
                end
            endcase
        end
        sz      = mstk.size();
        e.is_err = (e.code != 2'b00);
        e.tos   = (sz > 0) ? mstk[sz-1] : 16'h0;
        e.next  = (sz > 1) ? mstk[sz-2] : 16'h0;
        e.depth = sz;
        sb.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge where the result is visible.
    task automatic issue(input logic [1:0] k, input logic [3:0] s, input logic [15:0] l);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check("in_ready_wait", in_ready, 1);
        model_op(k, s, l);
        in_valid = 1'b1; in_kind = k; in_sel = s; in_lit = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(done || err) && n < 10);
        check("latency", n, 2);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("clr_in_ready", in_ready, 1);
        check("clr_err", err, 0);
        check("clr_err_code", err_code, 0);
    endtask

    always @(negedge clk) begin
        if (rst) err_prev = 1'b0;
        else begin
            if (done || (err && !err_prev)) begin
                if (sb.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_output: done=%0d err=%0d with empty scoreboard", done, err);
                end else begin
                    mon_e = sb.pop_front();
                    check("mon_is_err", err, mon_e.is_err);
                    check("mon_err_code", err_code, mon_e.code);
                    check("mon_tos", tos, mon_e.tos);
                    check("mon_next", next, mon_e.next);
                    check("mon_depth", depth, mon_e.depth);
                end
            end
            err_prev = err;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_tos", tos, 0);
        check("rst_next", next, 0);
        check("rst_depth", depth, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_select", alu_select, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset mid-EXEC of PUSH 5 aborts it.
        in_valid = 1'b1; in_kind = 2'd0; in_lit = 16'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t1_tos", tos, 0);
        check("t1_depth", depth, 0);
        check("t1_in_ready", in_ready, 1);
        check("t1_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t1_after_depth", depth, 0);

        // 2: 3 + 4.
        issue(2'd0, 4'h0, 16'd3);
        issue(2'd0, 4'h0, 16'd4);
        issue(2'd2, 4'h1, 16'd0);
        check("t2_tos", tos, 16'd7);
        check("t2_next", next, 0);
        check("t2_depth", depth, 1);
        issue(2'd1, 4'h0, 16'd0);

        // 3: swap then wrapping subtract.
        issue(2'd0, 4'h0, 16'd9);
        issue(2'd0, 4'h0, 16'd2);
        issue(2'd3, 4'hD, 16'd0);
        check("t3_swap_tos", tos, 16'd9);
        check("t3_swap_next", next, 16'd2);
        issue(2'd2, 4'h2, 16'd0);
        check("t3_sub_tos", tos, 16'hFFF9);
        check("t3_sub_depth", depth, 1);
        issue(2'd3, 4'hC, 16'd0);
        check("t3_inv_tos", tos, 16'h0006);
        issue(2'd1, 4'h0, 16'd0);
        issue(2'd3, 4'h0, 16'd0);
        check("t3_nop_depth", depth, 0);

        // 4: fill to capacity, overflow, then unwind through the spill RAM.
        for (int i = 1; i <= 18; i++) issue(2'd0, 4'h0, 16'(i));
        check("t4_full_depth", depth, 18);
        issue(2'd0, 4'h0, 16'd19);
        check("t4_err", err, 1);
        check("t4_err_code", err_code, 2'b01);
        check("t4_tos", tos, 16'd18);
        clear_err();
        for (int i = 17; i >= 0; i--) begin
            issue(2'd1, 4'h0, 16'd0);
            check("t4_drop_tos", tos, 16'(i));
        end
        check("t4_final_depth", depth, 0);

        // 5: underflow cases.
        issue(2'd1, 4'h0, 16'd0);
        check("t5_drop_code", err_code, 2'b10);
        clear_err();
        issue(2'd0, 4'h0, 16'd5);
        issue(2'd2, 4'h6, 16'd0);
        check("t5_bin_code", err_code, 2'b10);
        clear_err();
        issue(2'd1, 4'h0, 16'd0);

        // 6: illegal select; held in_valid ignored while in ERR.
        issue(2'd0, 4'h0, 16'd1);
        issue(2'd0, 4'h0, 16'd1);
        issue(2'd2, 4'h4, 16'd0);
        check("t6_err", err, 1);
        check("t6_code", err_code, 2'b11);
        in_valid = 1'b1; in_kind = 2'd0; in_lit = 16'd99;
        repeat (4) begin
            @(negedge clk);
            check("t6_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check("t6_tos", tos, 16'd1);
        check("t6_next", next, 16'd1);
        check("t6_depth", depth, 2);
        clear_err();
        check("t6_kept_depth", depth, 2);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
